if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC register and the IF/ID pipeline register, and talks to a variable-latency instruction memory over a req/ready handshake. It takes the redirect target (branch/j/jal/jr) computed in decode and applies it after the delay slot. It also handles decode back-pressure and misaligned fetch addresses.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, instruction word placed in IF/ID for bubbles and errors.

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall_d  in  1  decode stalled: IF/ID must hold its contents
redirect  in  1  decode instruction is a taken branch/j/jal/jr
redirect_pc  in  32  target address, valid when redirect=1
im_req  out  1  instruction memory request
im_addr  out  32  fetch address, equals pc_f
im_rdata  in  32  instruction word, valid when im_ready=1
im_ready  in  1  memory response this cycle for the outstanding request
pc_f  out  32  current fetch PC
instr_d  out  32  IF/ID instruction
pc_d  out  32  IF/ID PC
pc8_d  out  32  pc_d+8, used as the jal link value
valid_d  out  1  IF/ID holds a real instruction
addr_err_d  out  1  IF/ID entry comes from a misaligned fetch

Behaviour:
- Reset (synchronous): pc_f=RESET_PC; state=REQ; instr_d=NOP_INSTR; pc_d=0; pc8_d=8; valid_d=0; addr_err_d=0; pending redirect cleared; buffer cleared. im_req=0 while reset=1. im_ready is ignored in a reset cycle, and reset wins over every other event.
- States:
  - REQ (fetching)
  - BUF (instruction received, decode stalled)
  - ERR (fetch halted)
- im_req=1 only in REQ with pc_f[1:0]==0 and reset=0. im_addr=pc_f, held stable until im_ready.
- Redirect capture: take_now = redirect & valid_d & ~stall_d. The branch is leaving D, so the instruction now at pc_f is its delay slot.
- next_pc: if take_now, redirect_pc; else if pending_valid, pending_pc; else pc_f+4. Arithmetic wraps mod 2^32.
- take_now in a cycle where the delay slot is not accepted: pending_pc<=redirect_pc, pending_valid<=1.
- pending_valid clears when the delay slot is accepted.
- REQ, im_ready=1, stall_d=0 (accept):
  - IF/ID <= {im_rdata, pc_f, pc_f+8, valid=1, err=0}.
  - pc_f <= next_pc. Stay in REQ.
  - Zero-wait memory gives a throughput of 1 instr/cycle.
- REQ, im_ready=1, stall_d=1:
  - buffer <= im_rdata; go to BUF. pc_f holds; IF/ID holds.
- REQ, im_ready=0:
  - stall_d=0: IF/ID <= bubble (NOP_INSTR, valid_d=0, addr_err_d=0; pc_d/pc8_d unchanged).
  - stall_d=1: IF/ID holds.
- BUF:
  - im_req=0.
  - stall_d=1: hold everything.
  - stall_d=0: IF/ID <= {buffer, pc_f, pc_f+8, valid=1}; pc_f <= next_pc; go to REQ. No duplicate and no lost instruction.
- Misaligned fetch (in REQ, pc_f[1:0]!=0):
  - No request is issued.
  - When stall_d=0: IF/ID <= {NOP_INSTR, pc_f, pc_f+8, valid=1, err=1}; go to ERR.
- ERR: im_req=0; pc_f frozen; IF/ID holds when stall_d=1 and takes bubbles otherwise. Exit only via reset.
- The redirect input is ignored while valid_d=0.

Test Plan:
- Reset, zero-wait memory (im_ready=1 every cycle), no stalls -> pc_f steps 0x3000, 0x3004, 0x3008, ...; pc_d follows one cycle later; pc8_d=pc_d+8; valid_d=1 from the 2nd cycle after reset.
- beq at 0x3004 in D with redirect=1 and redirect_pc=0x3100 -> delay slot 0x3008 is fetched and enters D; the next pc_f is 0x3100.
- im_ready=1 arrives for 0x3008 while stall_d=1 for 3 cycles -> state BUF, im_req=0, pc_f stays 0x3008; when the stall drops, instr_d=that word with pc_d=0x3008, delivered exactly once, and pc_f=0x300C.
- Redirect to 0x3200 while the delay-slot fetch waits 4 cycles (im_ready=0) -> pending_valid=1; bubbles enter IF/ID; after the delay slot is accepted, pc_f=0x3200 and pending clears.
- jr redirect to 0x3102 -> delay slot fetched, then no im_req at 0x3102; IF/ID gets valid_d=1, addr_err_d=1, instr_d=0, pc_d=0x3102; im_req stays 0 until reset.
- Assert reset while in BUF with pending_valid=1 -> the next cycle shows pc_f=0x3000, valid_d=0, pending and buffer cleared; im_ready in the reset cycle has no effect.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, fetches over a
// req/ready handshake, applies decode redirects after the delay slot.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_d,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    input  logic        im_ready,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        valid_d,
    output logic        addr_err_d
);

    typedef enum logic [1:0] {
        ST_REQ = 2'd0,
        ST_BUF = 2'd1,
        ST_ERR = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d_s;
    logic [31:0] instr_q, instr_d_s;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pc8_q, pc8_d_s;
    logic        valid_q, valid_d_s;
    logic        err_q, err_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] buf_q, buf_d;

    logic        aligned_s;
    logic        take_now_s;
    logic        accept_s;
    logic [31:0] next_pc_s;

    assign aligned_s  = (pc_q[1:0] == 2'b00);
    assign take_now_s = redirect & valid_q & ~stall_d;
    assign im_req     = ~reset & (state_q == ST_REQ) & aligned_s;
    assign im_addr    = pc_q;
    assign pc_f       = pc_q;
    assign instr_d    = instr_q;
    assign pc_d       = pcd_q;
    assign pc8_d      = pc8_q;
    assign valid_d    = valid_q;
    assign addr_err_d = err_q;

    // Next-state, next-PC, IF/ID and pending-redirect computation.
    always_comb begin
        state_d      = state_q;
        pc_d_s       = pc_q;
        instr_d_s    = instr_q;
        pcd_d        = pcd_q;
        pc8_d_s      = pc8_q;
        valid_d_s    = valid_q;
        err_d        = err_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        buf_d        = buf_q;
        accept_s     = 1'b0;

        if (take_now_s) begin
            next_pc_s = redirect_pc;
        end else if (pend_valid_q) begin
            next_pc_s = pend_pc_q;
        end else begin
            next_pc_s = pc_q + 32'd4;
        end

        case (state_q)
            ST_REQ: begin
                if (!aligned_s) begin
                    if (!stall_d) begin
                        instr_d_s = NOP_INSTR;
                        pcd_d     = pc_q;
                        pc8_d_s   = pc_q + 32'd8;
                        valid_d_s = 1'b1;
                        err_d     = 1'b1;
                        state_d   = ST_ERR;
                    end else begin
                        state_d   = ST_REQ;
                    end
                end else if (im_ready) begin
                    if (!stall_d) begin
                        accept_s  = 1'b1;
                        instr_d_s = im_rdata;
                        pcd_d     = pc_q;
                        pc8_d_s   = pc_q + 32'd8;
                        valid_d_s = 1'b1;
                        err_d     = 1'b0;
                        pc_d_s    = next_pc_s;
                    end else begin
                        buf_d     = im_rdata;
                        state_d   = ST_BUF;
                    end
                end else begin
                    if (!stall_d) begin
                        instr_d_s = NOP_INSTR;
                        valid_d_s = 1'b0;
                        err_d     = 1'b0;
                    end else begin
                        state_d   = ST_REQ;
                    end
                end
            end
            ST_BUF: begin
                if (!stall_d) begin
                    accept_s  = 1'b1;
                    instr_d_s = buf_q;
                    pcd_d     = pc_q;
                    pc8_d_s   = pc_q + 32'd8;
                    valid_d_s = 1'b1;
                    err_d     = 1'b0;
                    pc_d_s    = next_pc_s;
                    state_d   = ST_REQ;
                end else begin
                    state_d   = ST_BUF;
                end
            end
            ST_ERR: begin
                if (!stall_d) begin
                    instr_d_s = NOP_INSTR;
                    valid_d_s = 1'b0;
                    err_d     = 1'b0;
                end else begin
                    state_d   = ST_ERR;
                end
            end
            default: begin
                instr_d_s = NOP_INSTR;
                valid_d_s = 1'b0;
                err_d     = 1'b0;
                state_d   = ST_ERR;
            end
        endcase

        // The redirect survives until its delay slot actually lands in IF/ID.
        if (accept_s) begin
            pend_valid_d = 1'b0;
        end else if (take_now_s) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = redirect_pc;
        end else begin
            pend_valid_d = pend_valid_q;
        end
    end

    // State, PC, IF/ID and redirect/buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            instr_q      <= NOP_INSTR;
            pcd_q        <= 32'h0000_0000;
            pc8_q        <= 32'h0000_0008;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'h0000_0000;
            buf_q        <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d_s;
            instr_q      <= instr_d_s;
            pcd_q        <= pcd_d;
            pc8_q        <= pc8_d_s;
            valid_q      <= valid_d_s;
            err_q        <= err_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            buf_q        <= buf_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Table-driven bench for if_fetch_stage with a scoreboard of IF/ID entries.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, stall_d, redirect, im_ready;
    logic [31:0] redirect_pc;
    logic        im_req;
    logic [31:0] im_addr, im_rdata, pc_f, instr_d, pc_d, pc8_d;
    logic        valid_d, addr_err_d;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          rst, stall, ready, redir;
        logic [31:0] rpc;
        logic [31:0] exp_pc;
        bit          exp_req, exp_valid, exp_err, acc;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } sb_t;

    vec_t vq[$];
    sb_t  sb[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h5A5A};
    endfunction

    // Memory returns garbage outside a ready cycle so stale data is visible.
    assign im_rdata = im_ready ? mem(im_addr) : 32'hDEAD_BEEF;

    if_fetch_stage dut (
        .clk(clk), .reset(reset), .stall_d(stall_d), .redirect(redirect),
        .redirect_pc(redirect_pc), .im_req(im_req), .im_addr(im_addr),
        .im_rdata(im_rdata), .im_ready(im_ready), .pc_f(pc_f),
        .instr_d(instr_d), .pc_d(pc_d), .pc8_d(pc8_d), .valid_d(valid_d),
        .addr_err_d(addr_err_d)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input bit rst, input bit stall, input bit ready, input bit redir,
                       input logic [31:0] rpc, input logic [31:0] pc, input bit req,
                       input bit v, input bit e, input bit acc);
        vec_t x;
        x.rst = rst; x.stall = stall; x.ready = ready; x.redir = redir; x.rpc = rpc;
        x.exp_pc = pc; x.exp_req = req; x.exp_valid = v; x.exp_err = e; x.acc = acc;
        vq.push_back(x);
    endtask

    initial begin
        sb_t e;
        // straight-line fetch and beq at 0x3004 redirecting to 0x3100
        add(0,0,1,0,32'h0,     32'h3000,1,1,0,1);
        add(0,0,1,0,32'h0,     32'h3004,1,1,0,1);
        add(0,0,1,1,32'h3100,  32'h3008,1,1,0,1);
        add(0,0,1,0,32'h0,     32'h3100,1,1,0,1);
        // stall while the response for 0x3008 arrives
        add(1,0,1,0,32'h0,     32'h3104,0,0,0,0);
        add(0,0,1,0,32'h0,     32'h3000,1,1,0,1);
        add(0,0,1,0,32'h0,     32'h3004,1,1,0,1);
        add(0,1,1,0,32'h0,     32'h3008,1,1,0,0);
        add(0,1,0,0,32'h0,     32'h3008,0,1,0,0);
        add(0,1,1,0,32'h0,     32'h3008,0,1,0,0);
        add(0,0,0,0,32'h0,     32'h3008,0,1,0,1);
        add(0,0,1,0,32'h0,     32'h300C,1,1,0,1);
        // redirect to 0x3200 while the delay slot waits; second redirect ignored
        add(1,0,1,0,32'h0,     32'h3010,0,0,0,0);
        add(0,0,1,0,32'h0,     32'h3000,1,1,0,1);
        add(0,0,1,0,32'h0,     32'h3004,1,1,0,1);
        add(0,0,0,1,32'h3200,  32'h3008,1,0,0,0);
        add(0,0,0,1,32'h3300,  32'h3008,1,0,0,0);
        add(0,0,0,0,32'h0,     32'h3008,1,0,0,0);
        add(0,0,0,0,32'h0,     32'h3008,1,0,0,0);
        add(0,0,1,0,32'h0,     32'h3008,1,1,0,1);
        add(0,0,1,0,32'h0,     32'h3200,1,1,0,1);
        add(0,0,1,0,32'h0,     32'h3204,1,1,0,1);
        // jr to misaligned 0x3102
        add(1,0,1,0,32'h0,     32'h3208,0,0,0,0);
        add(0,0,1,0,32'h0,     32'h3000,1,1,0,1);
        add(0,0,1,1,32'h3102,  32'h3004,1,1,0,1);
        add(0,0,1,0,32'h0,     32'h3102,0,1,1,1);
        add(0,0,1,0,32'h0,     32'h3102,0,0,0,0);
        add(0,1,1,0,32'h0,     32'h3102,0,0,0,0);
        add(0,0,1,0,32'h0,     32'h3102,0,0,0,0);
        // reset while in BUF with a pending redirect
        add(1,0,1,0,32'h0,     32'h3102,0,0,0,0);
        add(0,0,1,0,32'h0,     32'h3000,1,1,0,1);
        add(0,0,1,0,32'h0,     32'h3004,1,1,0,1);
        add(0,0,0,1,32'h3300,  32'h3008,1,0,0,0);
        add(0,1,1,0,32'h0,     32'h3008,1,0,0,0);
        add(1,0,1,0,32'h0,     32'h3008,0,0,0,0);
        add(0,0,1,0,32'h0,     32'h3000,1,1,0,1);
        add(0,0,1,0,32'h0,     32'h3004,1,1,0,1);
        add(0,0,1,0,32'h0,     32'h3008,1,1,0,1);
        add(0,0,1,0,32'h0,     32'h300C,1,1,0,1);

        // Hand-written reset sequence.
        reset = 1'b1; stall_d = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; im_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc_f",    pc_f,     32'h0000_3000);
        chk("rst_im_req",  {31'd0, im_req},     32'd0);
        chk("rst_valid",   {31'd0, valid_d},    32'd0);
        chk("rst_err",     {31'd0, addr_err_d}, 32'd0);
        chk("rst_instr",   instr_d,  32'h0000_0000);
        chk("rst_pc_d",    pc_d,     32'h0000_0000);
        chk("rst_pc8_d",   pc8_d,    32'h0000_0008);

        foreach (vq[i]) begin
            @(negedge clk);
            reset = vq[i].rst; stall_d = vq[i].stall; im_ready = vq[i].ready;
            redirect = vq[i].redir; redirect_pc = vq[i].rpc;
            #1;
            chk($sformatf("v%0d_pc_f", i), pc_f, vq[i].exp_pc);
            chk($sformatf("v%0d_im_addr", i), im_addr, vq[i].exp_pc);
            chk($sformatf("v%0d_im_req", i), {31'd0, im_req}, {31'd0, vq[i].exp_req});
            if (vq[i].acc) begin
                e.pc    = vq[i].exp_pc;
                e.instr = vq[i].exp_err ? 32'h0000_0000 : mem(vq[i].exp_pc);
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid_d", i), {31'd0, valid_d}, {31'd0, vq[i].exp_valid});
            chk($sformatf("v%0d_addr_err_d", i), {31'd0, addr_err_d}, {31'd0, vq[i].exp_err});
            if (vq[i].acc) begin
                e = sb.pop_front();
                chk($sformatf("v%0d_instr_d", i), instr_d, e.instr);
                chk($sformatf("v%0d_pc_d", i), pc_d, e.pc);
                chk($sformatf("v%0d_pc8_d", i), pc8_d, e.pc + 32'd8);
            end
            if (vq[i].rst) begin
                chk($sformatf("v%0d_rst_pc_f", i), pc_f, 32'h0000_3000);
                chk($sformatf("v%0d_rst_pc_d", i), pc_d, 32'h0000_0000);
                chk($sformatf("v%0d_rst_pc8_d", i), pc8_d, 32'h0000_0008);
                chk($sformatf("v%0d_rst_instr", i), instr_d, 32'h0000_0000);
            end
        end
        chk("sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
